loom_axil_ctrl_regs: RTL and testbench



---
 rtl/loom_axil_ctrl_regs.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_loom_axil_ctrl_regs.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/loom_axil_ctrl_regs.sv
// AXI-Lite control/status register block: ID, scratch, interrupt pending/enable/force,
// a sticky finish request and a free-running 64-bit cycle counter with a high-word snapshot.
module loom_axil_ctrl_regs #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned N_IRQ      = 16,
    parameter logic [31:0] ID_VALUE   = 32'h4C4F_4F4D
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr_i,
    input  logic                  s_axil_arvalid_i,
    output logic                  s_axil_arready_o,
    output logic [31:0]           s_axil_rdata_o,
    output logic [1:0]            s_axil_rresp_o,
    output logic                  s_axil_rvalid_o,
    input  logic                  s_axil_rready_i,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr_i,
    input  logic                  s_axil_awvalid_i,
    output logic                  s_axil_awready_o,
    input  logic [31:0]           s_axil_wdata_i,
    input  logic [3:0]            s_axil_wstrb_i,
    input  logic                  s_axil_wvalid_i,
    output logic                  s_axil_wready_o,
    output logic [1:0]            s_axil_bresp_o,
    output logic                  s_axil_bvalid_o,
    input  logic                  s_axil_bready_i,
    input  logic [N_IRQ-1:0]      irq_src_i,
    output logic [N_IRQ-1:0]      irq_o,
    output logic                  finish_o
);

    typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'b00, W_HAVE_AW = 2'b01, W_HAVE_W = 2'b10, W_RESP = 2'b11} w_state_e;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] zext_irq(input logic [N_IRQ-1:0] v);
        logic [31:0] r;
        r          = 32'h0000_0000;
        r[N_IRQ-1:0] = v;
        return r;
    endfunction

    r_state_e          r_state_q, r_state_d;
    w_state_e          w_state_q, w_state_d;
    logic [31:0]       rdata_q, rdata_d, wdata_q, wdata_d, scratch_q, scratch_d, snap_q, snap_d;
    logic [1:0]        rresp_q, rresp_d, bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d, bvalid_q, bvalid_d, finish_q, finish_d;
    logic              arready_q, arready_d, awready_q, awready_d, wready_q, wready_d;
    logic [5:0]        awidx_q, awidx_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [N_IRQ-1:0]  enable_q, enable_d, pending_q, pending_d, src_q, irq_q, irq_d;
    logic [63:0]       cycle_q, cycle_d;

    logic [5:0]        rd_idx_s, cm_idx_s;
    logic [31:0]       rd_val_s, cm_data_s, wmask_s, bmask_s;
    logic [3:0]        cm_strb_s;
    logic              rd_err_s, cm_s, wr_ok_s;
    logic [N_IRQ-1:0]  clr_s, force_s, rise_s;
    logic              unused_s;

    assign rd_idx_s = s_axil_araddr_i[7:2];
    assign unused_s = ^{s_axil_araddr_i[ADDR_WIDTH-1:8], s_axil_araddr_i[1:0],
                        s_axil_awaddr_i[ADDR_WIDTH-1:8], s_axil_awaddr_i[1:0]};

    // Read data mux: values seen by a read are the pre-write register contents
    always_comb begin
        rd_val_s = 32'h0000_0000;
        rd_err_s = 1'b0;
        case (rd_idx_s)
            6'd0:    rd_val_s = ID_VALUE;
            6'd1:    rd_val_s = scratch_q;
            6'd2:    rd_val_s = zext_irq(pending_q);
            6'd3:    rd_val_s = zext_irq(enable_q);
            6'd4:    rd_val_s = 32'h0000_0000;
            6'd5:    rd_val_s = {31'h0000_0000, finish_q};
            6'd6:    rd_val_s = cycle_q[31:0];
            6'd7:    rd_val_s = snap_q;
            default: rd_err_s = 1'b1;
        endcase
    end

    // Read channel FSM and CYCLE_LO snapshot capture
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rvalid_d  = rvalid_q;
        snap_d    = snap_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axil_arvalid_i) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_val_s;
                    rresp_d   = rd_err_s ? 2'b10 : 2'b00;
                    if (rd_idx_s == 6'd6) begin
                        snap_d = cycle_q[63:32];
                    end else begin
                        snap_d = snap_q;
                    end
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_RESP: begin
                if (s_axil_rready_i) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                end else begin
                    r_state_d = R_RESP;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
            end
        endcase
        arready_d = ~rvalid_d;
    end

    // Write channel FSM: AW and W are collected independently, commit once both are present
    always_comb begin
        w_state_d = w_state_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        bvalid_d  = bvalid_q;
        cm_s      = 1'b0;
        cm_idx_s  = awidx_q;
        cm_data_s = wdata_q;
        cm_strb_s = wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                if (s_axil_awvalid_i && s_axil_wvalid_i) begin
                    cm_s      = 1'b1;
                    cm_idx_s  = s_axil_awaddr_i[7:2];
                    cm_data_s = s_axil_wdata_i;
                    cm_strb_s = s_axil_wstrb_i;
                end else if (s_axil_awvalid_i) begin
                    w_state_d = W_HAVE_AW;
                    awidx_d   = s_axil_awaddr_i[7:2];
                end else if (s_axil_wvalid_i) begin
                    w_state_d = W_HAVE_W;
                    wdata_d   = s_axil_wdata_i;
                    wstrb_d   = s_axil_wstrb_i;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_HAVE_AW: begin
                if (s_axil_wvalid_i) begin
                    cm_s      = 1'b1;
                    cm_data_s = s_axil_wdata_i;
                    cm_strb_s = s_axil_wstrb_i;
                end else begin
                    w_state_d = W_HAVE_AW;
                end
            end
            W_HAVE_W: begin
                if (s_axil_awvalid_i) begin
                    cm_s     = 1'b1;
                    cm_idx_s = s_axil_awaddr_i[7:2];
                end else begin
                    w_state_d = W_HAVE_W;
                end
            end
            W_RESP: begin
                if (s_axil_bready_i) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                bvalid_d  = 1'b0;
            end
        endcase
        if (cm_s) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = (cm_idx_s[5:3] != 3'b000) ? 2'b10 : 2'b00;
        end else begin
            bresp_d = bresp_q;
        end
        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
    end

    // Register side effects of a committed write, interrupt capture and the cycle counter
    always_comb begin
        wr_ok_s   = cm_s && (cm_idx_s[5:3] == 3'b000);
        bmask_s   = strb_to_mask(cm_strb_s);
        wmask_s   = cm_data_s & bmask_s;
        scratch_d = scratch_q;
        enable_d  = enable_q;
        finish_d  = finish_q;
        clr_s     = '0;
        force_s   = '0;
        if (wr_ok_s) begin
            case (cm_idx_s[2:0])
                3'd1:    scratch_d = (scratch_q & ~bmask_s) | wmask_s;
                3'd2:    clr_s     = wmask_s[N_IRQ-1:0];
                3'd3:    enable_d  = (enable_q & ~bmask_s[N_IRQ-1:0]) | wmask_s[N_IRQ-1:0];
                3'd4:    force_s   = wmask_s[N_IRQ-1:0];
                3'd5:    finish_d  = finish_q | wmask_s[0];
                default: scratch_d = scratch_q;
            endcase
        end else begin
            scratch_d = scratch_q;
        end
        rise_s    = irq_src_i & ~src_q;
        // Set sources are OR-ed after the clear so a same-cycle edge or force wins
        pending_d = (pending_q & ~clr_s) | rise_s | force_s;
        irq_d     = pending_d & enable_d;
        cycle_d   = cycle_q + 64'd1;
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            rdata_q   <= 32'h0000_0000;
            rresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            snap_q    <= 32'h0000_0000;
            w_state_q <= W_IDLE;
            awidx_q   <= 6'd0;
            wdata_q   <= 32'h0000_0000;
            wstrb_q   <= 4'h0;
            bresp_q   <= 2'b00;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            scratch_q <= 32'h0000_0000;
            enable_q  <= '0;
            pending_q <= '0;
            src_q     <= '0;
            irq_q     <= '0;
            finish_q  <= 1'b0;
            cycle_q   <= 64'd0;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
            snap_q    <= snap_d;
            w_state_q <= w_state_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            bvalid_q  <= bvalid_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            scratch_q <= scratch_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            src_q     <= irq_src_i;
            irq_q     <= irq_d;
            finish_q  <= finish_d;
            cycle_q   <= cycle_d;
        end
    end

    assign s_axil_arready_o = arready_q;
    assign s_axil_rdata_o   = rdata_q;
    assign s_axil_rresp_o   = rresp_q;
    assign s_axil_rvalid_o  = rvalid_q;
    assign s_axil_awready_o = awready_q;
    assign s_axil_wready_o  = wready_q;
    assign s_axil_bresp_o   = bresp_q;
    assign s_axil_bvalid_o  = bvalid_q;
    assign irq_o            = irq_q;
    assign finish_o         = finish_q;

endmodule

// File: tb/tb_loom_axil_ctrl_regs.sv
// Directed bench for loom_axil_ctrl_regs; inputs change and outputs are sampled on the falling edge.
module tb_loom_axil_ctrl_regs;
    localparam int AW = 20;
    localparam int NI = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] araddr, awaddr;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   rdata, wdata;
    logic [1:0]    rresp, bresp;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]    wstrb;
    logic [NI-1:0] irq_src, irq;
    logic          finish;

    int total = 0;
    int bad   = 0;
    logic [63:0] cyc_m;
    logic [31:0] d;
    logic [1:0]  r;
    logic [63:0] c, c1;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_m <= 64'd0;
        else        cyc_m <= cyc_m + 64'd1;
    end

    loom_axil_ctrl_regs #(.ADDR_WIDTH(AW), .N_IRQ(NI), .ID_VALUE(32'h4C4F_4F4D)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_axil_araddr_i(araddr), .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
        .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
        .s_axil_rready_i(rready),
        .s_axil_awaddr_i(awaddr), .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
        .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
        .s_axil_wready_o(wready), .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid),
        .s_axil_bready_i(bready),
        .irq_src_i(irq_src), .irq_o(irq), .finish_o(finish)
    );

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] rd, output logic [1:0] rr,
                            output logic [63:0] hs);
        int n;
        @(negedge clk); araddr = a; arvalid = 1'b1; n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        hs = cyc_m;
        @(negedge clk); arvalid = 1'b0; rready = 1'b1; n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        total++;
        if (!rvalid) begin bad++; $display("FAIL read_timeout addr=%h rvalid=%b required=1", a, rvalid); end
        rd = rdata; rr = rresp;
        @(negedge clk); rready = 1'b0;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] ws,
                             output logic [1:0] br);
        int n;
        @(negedge clk); awaddr = a; awvalid = 1'b1; wdata = wd; wstrb = ws; wvalid = 1'b1; n = 0;
        while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        total++;
        if (!bvalid) begin bad++; $display("FAIL write_timeout addr=%h bvalid=%b required=1", a, bvalid); end
        br = bresp;
        @(negedge clk); bready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0; awaddr = '0; awvalid = 1'b0;
        wdata = '0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0; irq_src = '0;
        #12;
        total++; if ({arready, awready, wready, rvalid, bvalid, finish} !== 6'b111000) begin bad++;
            $display("FAIL reset_ctrl got=%b exp=111000", {arready, awready, wready, rvalid, bvalid, finish}); end
        total++; if ({rdata, rresp, bresp} !== 36'h0) begin bad++;
            $display("FAIL reset_data got=%h exp=0", {rdata, rresp, bresp}); end
        total++; if (irq !== 16'h0) begin bad++; $display("FAIL reset_irq got=%h exp=0", irq); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); araddr = 20'h00000; arvalid = 1'b1;
        @(negedge clk); arvalid = 1'b0;
        total++; if ({rvalid, arready, rresp} !== 4'b1000) begin bad++;
            $display("FAIL id_latency got=%b exp=1000", {rvalid, arready, rresp}); end
        total++; if (rdata !== 32'h4C4F4F4D) begin bad++; $display("FAIL id_rdata got=%h exp=4c4f4f4d", rdata); end
        rready = 1'b1;
        @(negedge clk); rready = 1'b0;
        total++; if ({rvalid, arready} !== 2'b01) begin bad++;
            $display("FAIL id_release got=%b exp=01", {rvalid, arready}); end
        axi_read(20'h00004, d, r, c);
        total++; if ({d, r} !== 34'h0) begin bad++; $display("FAIL scratch_reset got=%h exp=0", {d, r}); end
    endtask

    task automatic test_scratch;
        axi_write(20'h00004, 32'hAABBCCDD, 4'b0101, r);
        axi_read(20'h00004, d, r, c);
        total++; if (d !== 32'h00BB00DD) begin bad++; $display("FAIL scratch_strb got=%h exp=00bb00dd", d); end
        @(negedge clk); wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk); wvalid = 1'b0;
        total++; if ({wready, awready} !== 2'b01) begin bad++;
            $display("FAIL w_first_ready got=%b exp=01", {wready, awready}); end
        repeat (2) @(negedge clk);
        total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL w_first_early_b got=%b exp=0", bvalid); end
        awaddr = 20'h00004; awvalid = 1'b1;
        @(negedge clk); awvalid = 1'b0;
        total++; if ({bvalid, bresp, awready, wready} !== 5'b10000) begin bad++;
            $display("FAIL w_first_commit got=%b exp=10000", {bvalid, bresp, awready, wready}); end
        bready = 1'b1;
        @(negedge clk); bready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({bvalid, awready, wready} !== 3'b011) begin bad++;
            $display("FAIL w_first_single_b got=%b exp=011", {bvalid, awready, wready}); end
        axi_read(20'h00004, d, r, c);
        total++; if (d !== 32'h11223344) begin bad++; $display("FAIL w_first_data got=%h exp=11223344", d); end
    endtask

    task automatic test_irq;
        axi_write(20'h0000C, 32'h00000003, 4'hF, r);
        @(negedge clk); irq_src = 16'h0002;
        @(negedge clk); irq_src = 16'h0000;
        total++; if (irq !== 16'h0002) begin bad++; $display("FAIL irq_edge got=%h exp=0002", irq); end
        axi_read(20'h00008, d, r, c);
        total++; if (d !== 32'h00000002) begin bad++; $display("FAIL pending_edge got=%h exp=00000002", d); end
        @(negedge clk); awaddr = 20'h00008; awvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
        irq_src = 16'h0002;
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; irq_src = 16'h0000; bready = 1'b1;
        @(negedge clk); bready = 1'b0;
        axi_read(20'h00008, d, r, c);
        total++; if (d !== 32'h00000002) begin bad++; $display("FAIL set_beats_clear got=%h exp=00000002", d); end
        axi_write(20'h00008, 32'h00000002, 4'hF, r);
        axi_read(20'h00008, d, r, c);
        total++; if ({d, irq} !== 48'h0) begin bad++; $display("FAIL w1c got=%h exp=0", {d, irq}); end
    endtask

    task automatic test_force;
        axi_write(20'h0000C, 32'h0, 4'hF, r);
        axi_write(20'h00010, 32'h00008000, 4'hF, r);
        axi_read(20'h00008, d, r, c);
        total++; if ({d, irq} !== {32'h00008000, 16'h0000}) begin bad++;
            $display("FAIL force_pending got=%h exp=000080000000", {d, irq}); end
        axi_read(20'h00010, d, r, c);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL force_reads0 got=%h exp=0", d); end
        axi_write(20'h0000C, 32'h00008000, 4'hF, r);
        total++; if (irq !== 16'h8000) begin bad++; $display("FAIL force_irq got=%h exp=8000", irq); end
        axi_write(20'h0000C, 32'hFFFFFFFF, 4'hF, r);
        axi_read(20'h0000C, d, r, c);
        total++; if (d !== 32'h0000FFFF) begin bad++; $display("FAIL enable_width got=%h exp=0000ffff", d); end
        axi_write(20'h0000C, 32'h0, 4'hF, r);
        axi_write(20'h00008, 32'hFFFFFFFF, 4'hF, r);
    endtask

    task automatic test_error;
        axi_read(20'h00040, d, r, c);
        total++; if ({d, r} !== {32'h0, 2'b10}) begin bad++; $display("FAIL rd_slverr got=%h/%b exp=0/10", d, r); end
        axi_write(20'h00040, 32'hCAFEF00D, 4'hF, r);
        total++; if (r !== 2'b10) begin bad++; $display("FAIL wr_slverr got=%b exp=10", r); end
        axi_write(20'h00000, 32'hCAFEF00D, 4'hF, r);
        total++; if (r !== 2'b00) begin bad++; $display("FAIL wr_ro_okay got=%b exp=00", r); end
        axi_read(20'h00004, d, r, c);
        total++; if (d !== 32'h11223344) begin bad++; $display("FAIL slverr_nochange got=%h exp=11223344", d); end
        @(negedge clk); araddr = 20'h00103; arvalid = 1'b1;
        @(negedge clk); arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if ({rvalid, arready, rdata} !== {2'b10, 32'h4C4F4F4D}) begin bad++;
                $display("FAIL rready_hold%0d got=%b/%h exp=10/4c4f4f4d", i, {rvalid, arready}, rdata); end
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk); rready = 1'b0;
        total++; if ({rvalid, arready} !== 2'b01) begin bad++;
            $display("FAIL rready_done got=%b exp=01", {rvalid, arready}); end
    endtask

    task automatic test_cycle;
        axi_read(20'h00018, d, r, c1);
        total++; if (d !== c1[31:0]) begin bad++; $display("FAIL cycle_lo got=%h exp=%h", d, c1[31:0]); end
        repeat (10) @(negedge clk);
        axi_read(20'h0001C, d, r, c);
        total++; if (d !== c1[63:32]) begin bad++; $display("FAIL cycle_hi got=%h exp=%h", d, c1[63:32]); end
        axi_read(20'h00018, d, r, c);
        total++; if (d !== c[31:0]) begin bad++; $display("FAIL cycle_lo2 got=%h exp=%h", d, c[31:0]); end
    endtask

    task automatic test_finish;
        @(negedge clk); awaddr = 20'h00014; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'h1; wvalid = 1'b1;
        total++; if (finish !== 1'b0) begin bad++; $display("FAIL finish_early got=%b exp=0", finish); end
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
        total++; if ({finish, bvalid} !== 2'b11) begin bad++;
            $display("FAIL finish_set got=%b exp=11", {finish, bvalid}); end
        bready = 1'b1;
        @(negedge clk); bready = 1'b0;
        axi_write(20'h00014, 32'h0, 4'hF, r);
        axi_read(20'h00014, d, r, c);
        total++; if ({finish, d} !== {1'b1, 32'h1}) begin bad++;
            $display("FAIL finish_sticky got=%b/%h exp=1/00000001", finish, d); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk); wvalid = 1'b0; rst_n = 1'b0;
        #1;
        total++; if ({awready, wready, finish} !== 3'b110) begin bad++;
            $display("FAIL mid_reset got=%b exp=110", {awready, wready, finish}); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); awaddr = 20'h00004; awvalid = 1'b1;
        @(negedge clk); awvalid = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL mid_no_commit got=%b exp=0", bvalid); end
        wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk); wvalid = 1'b0; bready = 1'b1;
        @(negedge clk); bready = 1'b0;
        axi_read(20'h00004, d, r, c);
        total++; if (d !== 32'h5A5A5A5A) begin bad++; $display("FAIL mid_aw_then_w got=%h exp=5a5a5a5a", d); end
    endtask

    initial begin
        test_reset();
        test_scratch();
        test_irq();
        test_force();
        test_error();
        test_cycle();
        test_finish();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
